// File: rtl/riot_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// riot_bus_arbiter_if
// Bundle of the signals around the RIOT bus arbiter.
//   CPU side : cpu_cs, cpu_rw, cpu_rs, cpu_addr[6:0], cpu_din[7:0]  -> arbiter
//              cpu_dout[7:0], cpu_rdy                              <- arbiter
//   Host side: host_req, host_rw, host_rs, host_addr[6:0],
//              host_wdata[7:0]                                     -> arbiter
//              host_gnt, host_ack, host_rdata[7:0]                 <- arbiter
//   RIOT side: riot_cs, riot_rw, riot_rs, riot_addr[6:0],
//              riot_din[7:0]                                       <- arbiter
//              riot_dout[7:0]                                      -> arbiter
// Modports:
//   master : the surroundings (CPU decode, host requester, riot6532 instance)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface riot_bus_arbiter_if;
    logic       cpu_cs;
    logic       cpu_rw;
    logic       cpu_rs;
    logic [6:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_rdy;

    logic       host_req;
    logic       host_rw;
    logic       host_rs;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_ack;
    logic [7:0] host_rdata;

    logic       riot_cs;
    logic       riot_rw;
    logic       riot_rs;
    logic [6:0] riot_addr;
    logic [7:0] riot_din;
    logic [7:0] riot_dout;

    modport master (
        output cpu_cs, cpu_rw, cpu_rs, cpu_addr, cpu_din,
        input  cpu_dout, cpu_rdy,
        output host_req, host_rw, host_rs, host_addr, host_wdata,
        input  host_gnt, host_ack, host_rdata,
        input  riot_cs, riot_rw, riot_rs, riot_addr, riot_din,
        output riot_dout
    );

    modport slave (
        input  cpu_cs, cpu_rw, cpu_rs, cpu_addr, cpu_din,
        output cpu_dout, cpu_rdy,
        input  host_req, host_rw, host_rs, host_addr, host_wdata,
        output host_gnt, host_ack, host_rdata,
        output riot_cs, riot_rw, riot_rs, riot_addr, riot_din,
        input  riot_dout
    );
endinterface

// File: rtl/riot_bus_arbiter.sv
// ---------------------------------------------------------------------------
// riot_bus_arbiter
// Shares the RIOT 6532 register/RAM bus between the 6502 CPU and a host
// requester. The CPU always wins; the host is slotted into idle cycles via a
// req/gnt/ack handshake (IDLE -> ISSUE -> CAPTURE, 3 cycles per access).
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : riot_bus_arbiter_if.slave (CPU, host and RIOT bus signals)
//
// Parameters:
//   STARVE_LIMIT : blocked ISSUE cycles before the host is forced on the bus
//   CNT_W        : starvation counter width, 2**CNT_W > STARVE_LIMIT
//
// Build option:
//   RIOT_STARVE_GUARD_EN : when defined, a starvation counter stalls the CPU
//                          for one cycle (cpu_rdy=0) and grants the host after
//                          STARVE_LIMIT blocked cycles. When undefined,
//                          cpu_rdy is tied high and the host can be starved.
// ---------------------------------------------------------------------------
module riot_bus_arbiter #(
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    riot_bus_arbiter_if.slave bus
);

    if (2**CNT_W <= STARVE_LIMIT) begin : g_cnt_w_check
        $error("riot_bus_arbiter: CNT_W too narrow for STARVE_LIMIT");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] rdata_reg;
    logic [7:0] hold_reg;
    logic       owner_cpu_reg;   // 1: last RIOT access was made by the CPU
    logic       cpu_read_reg;    // CPU read strobed last cycle

    logic       cpu_sel;
    logic       host_turn;

    // CPU owns the bus whenever it selects the RIOT and is not being stalled.
    assign cpu_sel   = bus.cpu_cs & bus.cpu_rdy;
    // A dropped request never strobes the RIOT, even while still in ISSUE.
    assign host_turn = (state_reg == ISSUE) & bus.host_req & ~cpu_sel;

`ifdef RIOT_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_reg;
    logic             force_host;

    assign force_host  = (state_reg == ISSUE) & bus.host_req &
                         (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    assign bus.cpu_rdy = ~force_host;

    // Counts consecutive cycles the pending host access lost to the CPU.
    // Any other situation (grant, IDLE, CAPTURE) restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if ((state_reg == ISSUE) && bus.host_req && cpu_sel) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end else begin
            starve_cnt_reg <= '0;
        end
    end
`else
    assign bus.cpu_rdy = 1'b1;
`endif

    // Combinational bus mux. When nobody accesses, the CPU fields still drive
    // the bus so the idle pattern is identical to a bus without the arbiter.
    always_comb begin
        bus.riot_cs   = 1'b0;
        bus.riot_rw   = bus.cpu_rw;
        bus.riot_rs   = bus.cpu_rs;
        bus.riot_addr = bus.cpu_addr;
        bus.riot_din  = bus.cpu_din;
        if (cpu_sel) begin
            bus.riot_cs = 1'b1;
        end else if (host_turn) begin
            bus.riot_cs   = 1'b1;
            bus.riot_rw   = bus.host_rw;
            bus.riot_rs   = bus.host_rs;
            bus.riot_addr = bus.host_addr;
            bus.riot_din  = bus.host_wdata;
        end
    end

    assign bus.host_gnt = host_turn;
    assign bus.host_ack = (state_reg == CAPTURE);
    // The RIOT presents the read data during CAPTURE; bypass it so the data is
    // valid together with the ack, then hold it in rdata_reg until next ack.
    assign bus.host_rdata = ((state_reg == CAPTURE) && bus.host_rw) ?
                            bus.riot_dout : rdata_reg;
    // Host reads change riot_dout; the CPU then sees its own last read value.
    assign bus.cpu_dout = owner_cpu_reg ? bus.riot_dout : hold_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rdata_reg     <= 8'h00;
            hold_reg      <= 8'h00;
            owner_cpu_reg <= 1'b1;
            cpu_read_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.host_req) begin
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.host_req) begin
                        state_reg <= IDLE;
                    end else if (host_turn) begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.host_rw) begin
                        rdata_reg <= bus.riot_dout;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (bus.riot_cs) begin
                owner_cpu_reg <= cpu_sel;
            end
            cpu_read_reg <= cpu_sel & bus.cpu_rw;
            // riot_dout carries the CPU read result the cycle after the read.
            if (cpu_read_reg) begin
                hold_reg <= bus.riot_dout;
            end
        end
    end

endmodule

// File: tb/tb_riot_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riot_bus_arbiter
// Bench for riot_bus_arbiter with a small behavioural RIOT (256-byte store
// indexed by {rs, addr}, registered read data). Stimulus pushes expected
// host/CPU read results into queues; a monitor pops and compares whenever
// host_ack fires or a CPU read result is due. Timing checks are directed.
// ---------------------------------------------------------------------------
module tb_riot_bus_arbiter;

    logic clk;
    logic reset;
    logic model_load;

    riot_bus_arbiter_if bus();

    riot_bus_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W       (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RIOT ----------------
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (model_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h82] <= 8'h33;            // DRB preset
            bus.riot_dout <= 8'h00;
        end else if (bus.riot_cs) begin
            if (!bus.riot_rw) mem[{bus.riot_rs, bus.riot_addr}] <= bus.riot_din;
            else              bus.riot_dout <= mem[{bus.riot_rs, bus.riot_addr}];
        end
    end

    // ---------------- scoreboard ----------------
    int n_total;
    int n_pass;
    int ack_cnt;
    string      host_name_q[$];
    logic [7:0] host_data_q[$];
    string      cpu_name_q[$];
    logic [7:0] cpu_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic cpu_rd_pending;
    always @(posedge clk)
        cpu_rd_pending <= !reset && bus.cpu_cs && bus.cpu_rdy && bus.cpu_rw;

    always @(negedge clk) begin
        if (bus.host_ack) begin
            ack_cnt++;
            if (host_name_q.size() == 0) begin
                check("unexpected_host_ack", 32'd1, 32'd0);
            end else begin
                string nm;
                logic [7:0] ed;
                nm = host_name_q.pop_front();
                ed = host_data_q.pop_front();
                $display("host ack  %s rdata=%02h", nm, bus.host_rdata);
                check(nm, {24'h0, bus.host_rdata}, {24'h0, ed});
            end
        end
        if (cpu_rd_pending) begin
            if (cpu_name_q.size() == 0) begin
                check("unexpected_cpu_read", 32'd1, 32'd0);
            end else begin
                string nm;
                logic [7:0] ed;
                nm = cpu_name_q.pop_front();
                ed = cpu_data_q.pop_front();
                $display("cpu read  %s dout=%02h", nm, bus.cpu_dout);
                check(nm, {24'h0, bus.cpu_dout}, {24'h0, ed});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle; reads register their expected data in the scoreboard.
    task automatic cpu_access(input logic rw, input logic rs, input logic [6:0] addr,
                              input logic [7:0] din, input logic [7:0] exp, input string name);
        bus.cpu_cs = 1'b1; bus.cpu_rw = rw; bus.cpu_rs = rs;
        bus.cpu_addr = addr; bus.cpu_din = din;
        if (rw) begin
            cpu_name_q.push_back(name);
            cpu_data_q.push_back(exp);
        end
        tick();
        bus.cpu_cs = 1'b0;
    endtask

    // Full host transaction; reports grant/ack cycle offsets from request.
    task automatic host_access(input logic rw, input logic rs, input logic [6:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp, input string name,
                               output int gnt_at, output int ack_at);
        host_name_q.push_back(name);
        host_data_q.push_back(exp);
        bus.host_req = 1'b1; bus.host_rw = rw; bus.host_rs = rs;
        bus.host_addr = addr; bus.host_wdata = wdata;
        gnt_at = -1;
        ack_at = -1;
        for (int n = 0; n < 20 && ack_at < 0; n++) begin
            @(negedge clk);
            if (bus.host_gnt && gnt_at < 0) gnt_at = n;
            if (bus.host_ack) ack_at = n;
        end
        if (ack_at < 0) check({name, "_ack_timeout"}, 32'd0, 32'd1);
        tick();
        bus.host_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int g, a, acks_before;
        int gnt_cnt, rdy_low, first_gnt, first_rdy;
        logic acked;

        n_total = 0; n_pass = 0; ack_cnt = 0;
        reset = 1'b1; model_load = 1'b1;
        bus.cpu_cs = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_rs = 1'b0;
        bus.cpu_addr = 7'h00; bus.cpu_din = 8'h00;
        bus.host_req = 1'b0; bus.host_rw = 1'b1; bus.host_rs = 1'b0;
        bus.host_addr = 7'h00; bus.host_wdata = 8'h00;
        repeat (3) tick();
        reset = 1'b0; model_load = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_host_gnt",   {31'h0, bus.host_gnt}, 32'd0);
        check("rst_host_ack",   {31'h0, bus.host_ack}, 32'd0);
        check("rst_host_rdata", {24'h0, bus.host_rdata}, 32'h00);
        check("rst_cpu_rdy",    {31'h0, bus.cpu_rdy}, 32'd1);
        check("rst_riot_cs",    {31'h0, bus.riot_cs}, 32'd0);
        tick();

        // host write DDRA on an idle bus, then CPU reads it back
        host_access(1'b0, 1'b1, 7'h01, 8'hFF, 8'h00, "host_wr_ddra", g, a);
        check("wr_ddra_gnt_cycle", g, 32'd1);
        check("wr_ddra_ack_cycle", a, 32'd2);
        cpu_access(1'b1, 1'b1, 7'h01, 8'h00, 8'hFF, "cpu_rd_ddra");

        // host read of CPU-written RAM
        cpu_access(1'b0, 1'b0, 7'h10, 8'h5A, 8'h00, "cpu_wr_ram10");
        host_access(1'b1, 1'b0, 7'h10, 8'h00, 8'h5A, "host_rd_ram10", g, a);

        // collision: CPU selects in the cycle the host enters ISSUE
        host_name_q.push_back("collide_wr_ack");
        host_data_q.push_back(8'h5A);
        bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_rs = 1'b0;
        bus.host_addr = 7'h20; bus.host_wdata = 8'hA5;
        tick();
        bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_rs = 1'b0;
        bus.cpu_addr = 7'h21; bus.cpu_din = 8'h11;
        @(negedge clk);
        check("collide_gnt_blocked", {31'h0, bus.host_gnt}, 32'd0);
        check("collide_cpu_addr",    {25'h0, bus.riot_addr}, 32'h21);
        tick();
        bus.cpu_cs = 1'b0;
        @(negedge clk);
        check("collide_gnt_after",   {31'h0, bus.host_gnt}, 32'd1);
        check("collide_host_addr",   {25'h0, bus.riot_addr}, 32'h20);
        tick();
        @(negedge clk);
        tick();
        bus.host_req = 1'b0;
        cpu_access(1'b1, 1'b0, 7'h20, 8'h00, 8'hA5, "cpu_rd_ram20");
        cpu_access(1'b1, 1'b0, 7'h21, 8'h00, 8'h11, "cpu_rd_ram21");

        // CPU read isolation
        cpu_access(1'b1, 1'b1, 7'h02, 8'h00, 8'h33, "cpu_rd_drb");
        host_access(1'b1, 1'b1, 7'h03, 8'h00, 8'h00, "host_rd_ddrb", g, a);
        @(negedge clk);
        check("isolation_cpu_dout", {24'h0, bus.cpu_dout}, 32'h33);
        tick();

        // request withdrawn while blocked in ISSUE: no grant, no ack
        acks_before = ack_cnt;
        bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_rs = 1'b0;
        bus.host_addr = 7'h12; bus.host_wdata = 8'hEE;
        tick();
        bus.host_req = 1'b0;
        bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 7'h12; bus.cpu_din = 8'h01;
        @(negedge clk);
        check("drop_gnt_issue", {31'h0, bus.host_gnt}, 32'd0);
        tick();
        bus.cpu_cs = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("drop_no_ack", ack_cnt - acks_before, 32'd0);
        tick();

        // starvation: CPU holds cpu_cs while the host waits
`ifdef RIOT_STARVE_GUARD_EN
        host_name_q.push_back("starve_wr_ack");
        host_data_q.push_back(8'h00);
`endif
        bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_rs = 1'b0;
        bus.host_addr = 7'h30; bus.host_wdata = 8'h77;
        bus.cpu_cs = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_rs = 1'b0;
        bus.cpu_addr = 7'h11; bus.cpu_din = 8'h22;
        gnt_cnt = 0; rdy_low = 0; first_gnt = -1; first_rdy = -1; acked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.host_gnt) begin gnt_cnt++; if (first_gnt < 0) first_gnt = i; end
            if (!bus.cpu_rdy) begin rdy_low++; if (first_rdy < 0) first_rdy = i; end
            if (bus.host_ack) acked = 1'b1;
            tick();
            if (acked) bus.host_req = 1'b0;
        end
        bus.cpu_cs = 1'b0;
        bus.host_req = 1'b0;
`ifdef RIOT_STARVE_GUARD_EN
        check("starve_gnt_count",   gnt_cnt, 32'd1);
        check("starve_rdy_low",     rdy_low, 32'd1);
        check("starve_gnt_cycle",   first_gnt, 32'd5);
        check("starve_rdy_cycle",   first_rdy, 32'd5);
        tick();
        cpu_access(1'b1, 1'b0, 7'h30, 8'h00, 8'h77, "cpu_rd_ram30");
`else
        check("starve_gnt_count",   gnt_cnt, 32'd0);
        check("starve_rdy_low",     rdy_low, 32'd0);
        repeat (2) tick();
`endif

        // reset during the grant cycle: no ack, write already in the RIOT
        bus.host_req = 1'b1; bus.host_rw = 1'b0; bus.host_rs = 1'b0;
        bus.host_addr = 7'h40; bus.host_wdata = 8'h99;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_gnt", {31'h0, bus.host_gnt}, 32'd1);
        tick();
        reset = 1'b0;
        bus.host_req = 1'b0;
        @(negedge clk);
        check("rstmid_no_ack",  {31'h0, bus.host_ack}, 32'd0);
        check("rstmid_cpu_rdy", {31'h0, bus.cpu_rdy}, 32'd1);
        check("rstmid_gnt_off", {31'h0, bus.host_gnt}, 32'd0);
        tick();
        cpu_access(1'b1, 1'b0, 7'h40, 8'h00, 8'h99, "cpu_rd_ram40");
        repeat (3) tick();

        check("host_q_drained", host_name_q.size(), 32'd0);
        check("cpu_q_drained",  cpu_name_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
